// File: rtl/hazard_unit_md.sv
// Pipeline hazard unit: forwarding selects, load/branch/mul-div stalls and a mul/div tracker FSM.
// Optional saturating stall/flush counters are enabled with the HAZARD_PERF_COUNT_EN macro.
module hazard_unit_md #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              start_mdE,
    input  logic              divE,
    input  logic              hiloD,
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              md_busy,
    output logic              md_done,
    output logic              md_err,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_cycles
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [REG_AW-1:0] src_e [2];
    logic [REG_AW-1:0] src_d [2];
    logic [1:0]        fwd_e [2];
    logic              fwd_d [2];

    assign src_e[0] = RsE;
    assign src_e[1] = RtE;
    assign src_d[0] = RsD;
    assign src_d[1] = RtD;

    // M-stage result has priority over W since it is the younger write.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_e[gi] = (src_e[gi] != '0 && src_e[gi] == writeregM && regwriteM) ? 2'b10 :
                               (src_e[gi] != '0 && src_e[gi] == writeregW && regwriteW) ? 2'b01 :
                                                                                          2'b00;
            assign fwd_d[gi] = (src_d[gi] != '0) && (src_d[gi] == writeregM) && regwriteM;
        end
    endgenerate

    assign forwardAE = fwd_e[0];
    assign forwardBE = fwd_e[1];
    assign forwardAD = fwd_d[0];
    assign forwardBD = fwd_d[1];

    logic lwstall, branchstall, mdstall;

    assign lwstall = memtoregE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));

    assign branchstall = branchD &&
        ((regwriteE && writeregE != '0 && (writeregE == RsD || writeregE == RtD)) ||
         (memtoregM && writeregM != '0 && (writeregM == RsD || writeregM == RtD)));

    assign mdstall = hiloD && (start_mdE || state == BUSY);

    assign stallD = lwstall | branchstall | mdstall;
    assign stallF = stallD;
    assign flushE = stallD;

    // A start while BUSY does not reload cnt; the running operation keeps counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
            md_err  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_mdE) begin
                        state   <= BUSY;
                        cnt     <= divE ? DIV_LOAD : MUL_LOAD;
                        md_busy <= 1'b1;
                        md_done <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                        md_done <= 1'b0;
                    end
                end
                BUSY: begin
                    if (start_mdE) begin
                        md_err <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state   <= DONE;
                        md_busy <= 1'b0;
                        md_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                    md_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_COUNT_EN
    logic [PERF_W-1:0] stall_cnt_reg;
    logic [PERF_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stallD && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (flushE && flush_cnt_reg != '1) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_cycles = flush_cnt_reg;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_md.sv
// Scoreboard bench for hazard_unit_md: directed scenarios then random traffic against a cycle-indexed model.
module tb_hazard_unit_md;

    localparam int AW    = 5;
    localparam int MLAT  = 4;
    localparam int DLAT  = 7;
    localparam int PW    = 4;
    localparam int PMAX  = (1 << PW) - 1;

    logic clk;
    logic reset_n;
    logic [AW-1:0] RsD, RtD, RsE, RtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic branchD, start_mdE, divE, hiloD;
    logic stallF, stallD, flushE, forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic md_busy, md_done, md_err;
    logic [PW-1:0] stall_cycles, flush_cycles;

    hazard_unit_md #(.REG_AW(AW), .MUL_LAT(MLAT), .DIV_LAT(DLAT), .PERF_W(PW)) dut (
        .clk(clk), .reset_n(reset_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .start_mdE(start_mdE), .divE(divE), .hiloD(hiloD),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .md_busy(md_busy), .md_done(md_done), .md_err(md_err),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rsd, rtd, rse, rte, we, wm, ww;
        logic rwe, rwm, rww, mte, mtm, br, start, div, hilo, rst_n;
    } stim_t;

    typedef struct {
        int  idx;
        logic [1:0] fae, fbe;
        logic fad, fbd, stall;
        logic busy, done, err;
        logic [PW-1:0] scnt, fcnt;
    } exp_t;

    exp_t  sb_q[$];
    stim_t s;
    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    // Model: an operation is described by the cycle range it occupies, not by a counter.
    int cyc = 0;
    int busy_first = -100;
    int busy_last  = -100;
    bit m_err = 0;
    int m_scnt = 0;
    int m_fcnt = 0;

    function automatic logic [1:0] ref_fwd_e(logic [AW-1:0] src, stim_t t);
        if (src != 0 && src == t.wm && t.rwm) return 2'b10;
        if (src != 0 && src == t.ww && t.rww) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit in_pair(logic [AW-1:0] r, logic [AW-1:0] a, logic [AW-1:0] b);
        return (r == a) || (r == b);
    endfunction

    function automatic bit ref_stall(stim_t t, bit busy_now);
        bit lw, brs, md;
        lw  = t.mte && t.rte != 0 && in_pair(t.rte, t.rsd, t.rtd);
        brs = t.br && ((t.rwe && t.we != 0 && in_pair(t.we, t.rsd, t.rtd)) ||
                       (t.mtm && t.wm != 0 && in_pair(t.wm, t.rsd, t.rtd)));
        md  = t.hilo && (t.start || busy_now);
        return lw || brs || md;
    endfunction

    function automatic bit model_busy();
        return cyc >= busy_first && cyc <= busy_last;
    endfunction

    task automatic model_clear();
        busy_first = -100;
        busy_last  = -100;
        m_err  = 0;
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    task automatic cycle();
        exp_t e;
        bit st;
        RsD = s.rsd; RtD = s.rtd; RsE = s.rse; RtE = s.rte;
        writeregE = s.we; writeregM = s.wm; writeregW = s.ww;
        regwriteE = s.rwe; regwriteM = s.rwm; regwriteW = s.rww;
        memtoregE = s.mte; memtoregM = s.mtm; branchD = s.br;
        start_mdE = s.start; divE = s.div; hiloD = s.hilo; reset_n = s.rst_n;
        if (!s.rst_n) model_clear();
        st = ref_stall(s, model_busy());
        e.idx   = n_txn;
        e.fae   = ref_fwd_e(s.rse, s);
        e.fbe   = ref_fwd_e(s.rte, s);
        e.fad   = s.rsd != 0 && s.rsd == s.wm && s.rwm;
        e.fbd   = s.rtd != 0 && s.rtd == s.wm && s.rwm;
        e.stall = st;
        e.busy  = model_busy();
        e.done  = (cyc == busy_last + 1);
        e.err   = m_err;
`ifdef HAZARD_PERF_COUNT_EN
        e.scnt  = PW'(m_scnt);
        e.fcnt  = PW'(m_fcnt);
`else
        e.scnt  = '0;
        e.fcnt  = '0;
`endif
        sb_q.push_back(e);
        n_txn++;
        @(posedge clk);
        if (s.rst_n) begin
            if (s.start) begin
                if (model_busy()) m_err = 1;
                else begin
                    busy_first = cyc + 1;
                    busy_last  = cyc + (s.div ? DLAT : MLAT);
                end
            end
            if (st && m_scnt < PMAX) m_scnt++;
            if (st && m_fcnt < PMAX) m_fcnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s txn=%0d got=%0h want=%0h", name, idx, act, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("forwardAE", e.idx, 16'(forwardAE), 16'(e.fae));
            chk("forwardBE", e.idx, 16'(forwardBE), 16'(e.fbe));
            chk("forwardAD", e.idx, 16'(forwardAD), 16'(e.fad));
            chk("forwardBD", e.idx, 16'(forwardBD), 16'(e.fbd));
            chk("stallD",    e.idx, 16'(stallD),    16'(e.stall));
            chk("stallF",    e.idx, 16'(stallF),    16'(e.stall));
            chk("flushE",    e.idx, 16'(flushE),    16'(e.stall));
            chk("md_busy",   e.idx, 16'(md_busy),   16'(e.busy));
            chk("md_done",   e.idx, 16'(md_done),   16'(e.done));
            chk("md_err",    e.idx, 16'(md_err),    16'(e.err));
            chk("stall_cycles", e.idx, 16'(stall_cycles), 16'(e.scnt));
            chk("flush_cycles", e.idx, 16'(flush_cycles), 16'(e.fcnt));
            $display("txn %0d: fAE=%b fBE=%b stall=%b busy=%b done=%b err=%b scnt=%0d",
                     e.idx, forwardAE, forwardBE, stallD, md_busy, md_done, md_err, stall_cycles);
        end
    end

    task automatic idle_stim();
        s = '{default: '0};
        s.rst_n = 1'b1;
    endtask

    initial begin
        idle_stim();
        s.rst_n = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle();
        idle_stim();

        // Forwarding priority M over W, then W, then r0 suppression.
        s.rse = 3; s.wm = 3; s.rwm = 1; s.ww = 3; s.rww = 1; cycle();
        s.rwm = 0; cycle();
        s.rse = 0; cycle();
        idle_stim();

        // Load-use stall and its r0 exemption.
        s.mte = 1; s.rte = 5; s.rsd = 5; cycle();
        s.rte = 0; cycle();
        idle_stim();

        // Branch stall on E-stage writer, suppressed for r0.
        s.br = 1; s.rwe = 1; s.we = 7; s.rtd = 7; cycle();
        s.we = 0; cycle();
        idle_stim();

        // Multiply with hiloD held; a second start mid-BUSY raises sticky md_err.
        s.hilo = 1; s.start = 1; cycle();
        s.start = 0; cycle();
        s.start = 1; cycle();
        s.start = 0; repeat (6) cycle();
        idle_stim();

        // Divide interrupted by reset while BUSY.
        s.start = 1; s.div = 1; cycle();
        s.start = 0; repeat (3) cycle();
        s.rst_n = 0; cycle();
        s.rst_n = 1; repeat (2) cycle();

        // Hold a load-use stall for 20 cycles to drive the counters into saturation.
        s.mte = 1; s.rte = 9; s.rtd = 9; repeat (20) cycle();
        idle_stim();
        cycle();

        // Randomized traffic with small register indices to provoke matches.
        repeat (400) begin
            s.rsd = AW'($urandom_range(0, 3)); s.rtd = AW'($urandom_range(0, 3));
            s.rse = AW'($urandom_range(0, 3)); s.rte = AW'($urandom_range(0, 3));
            s.we  = AW'($urandom_range(0, 3)); s.wm  = AW'($urandom_range(0, 3));
            s.ww  = AW'($urandom_range(0, 3));
            s.rwe = 1'($urandom); s.rwm = 1'($urandom); s.rww = 1'($urandom);
            s.mte = ($urandom_range(0, 3) == 0); s.mtm = ($urandom_range(0, 3) == 0);
            s.br  = ($urandom_range(0, 3) == 0);
            s.start = ($urandom_range(0, 5) == 0);
            s.div   = 1'($urandom);
            s.hilo  = ($urandom_range(0, 2) == 0);
            s.rst_n = ($urandom_range(0, 59) != 0);
            cycle();
        end

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
